// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority output multiplexer.
package mux_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection over a request vector; owns the last-grant pointer used for round-robin.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int ARB_MODE = ARB_RR,
   localparam int SEL_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx
);

   logic [SEL_W-1:0] last_grant_q;
   logic [SEL_W-1:0] last_grant_d;
   logic [SEL_W-1:0] start_idx;
   logic             found;
   int               idx;

   // Search begins one past the last winner; fixed priority always begins at channel 0.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      if (ARB_MODE == ARB_FIXED || last_grant_q == SEL_W'(NUM_CH - 1)) begin
         start_idx = '0;
      end else begin
         start_idx = last_grant_q + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(start_idx) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance) last_grant_d = grant_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= SEL_W'(NUM_CH - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mux_rr_arb.sv
// N:1 registered multiplexer with valid/ready handshaking and internal arbitration.
// Valid/ready: a beat transfers on any cycle where valid and ready are both high.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DW       = 2,
   parameter int ARB_MODE = ARB_RR,
   localparam int SEL_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    in_valid,
   input  logic [NUM_CH*DW-1:0] in_data,
   output logic [NUM_CH-1:0]    in_ready,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   logic              accept;
   logic              hs_in;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic [DW-1:0]     sel_data;

   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_sel_q, out_sel_d;

   // The register can load when empty or when its beat leaves this same cycle.
   assign accept   = !out_valid_q || out_ready;
   assign in_ready = (accept && !rst) ? grant : '0;
   assign hs_in    = |(in_valid & in_ready);

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (hs_in),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (grant[k]) sel_data = in_data[k*DW +: DW];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (hs_in) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_sel_d   = grant_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
